// File: rtl/cpu_pkg.sv
// Shared definitions for the memory controller: FSM state type,
// load/store width encodings and the memory-mapped IO address match.
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      IC_READ,
      LSB_READ,
      LSB_WRITE,
      DONE
   } mem_state_e;

   localparam logic [1:0] LSB_WIDTH_BYTE = 2'd0;
   localparam logic [1:0] LSB_WIDTH_HALF = 2'd1;
   localparam logic [1:0] LSB_WIDTH_WORD = 2'd2;

   // Address bits [17:16] equal to this value select the UART/IO region.
   localparam logic [1:0] IO_ADDR_SEL = 2'b11;

   // Number of bytes moved by a load/store of the given width code.
   function automatic int unsigned lsb_bytes(input logic [1:0] width);
      case (width)
         LSB_WIDTH_BYTE: return 1;
         LSB_WIDTH_HALF: return 2;
         default:        return 4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating I-cache block fills and
// load/store requests onto a single 8-bit RAM port.
// Optional feature: define MEM_CTRL_IO_FULL_STALL_EN to hold IO-region
// store bytes while the UART transmit buffer is full.
module mem_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned ICACHE_BLOCK_BYTES = 8,
   parameter int unsigned ADDR_WIDTH         = 32
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            rdy_in,
   input  logic                            clear_in,
   input  logic [7:0]                      mem_din,
   output logic [7:0]                      mem_dout,
   output logic [31:0]                     mem_a,
   output logic                            mem_wr,
   input  logic                            io_buffer_full,
   input  logic                            ic_req,
   input  logic [ADDR_WIDTH-1:0]           ic_addr,
   output logic                            ic_done,
   output logic [8*ICACHE_BLOCK_BYTES-1:0] ic_block,
   input  logic                            lsb_req,
   input  logic                            lsb_wr,
   input  logic [1:0]                      lsb_width,
   input  logic [31:0]                     lsb_addr,
   input  logic [31:0]                     lsb_wdata,
   output logic                            lsb_done,
   output logic [31:0]                     lsb_rdata
);

   localparam int unsigned BUF_BYTES = (ICACHE_BLOCK_BYTES > 4) ? ICACHE_BLOCK_BYTES : 4;
   localparam int unsigned BUF_W     = 8 * BUF_BYTES;
   localparam int unsigned CW        = $clog2(BUF_BYTES + 1);

   mem_state_e                      state_q;
   logic [CW-1:0]                   cnt_q;
   logic [CW-1:0]                   len_q;
   logic [BUF_W-1:0]                shreg_q;
   logic [BUF_W-1:0]                asm_d;
   logic [31:0]                     mem_a_q;
   logic [7:0]                      mem_dout_q;
   logic                            mem_wr_q;
   logic                            ic_done_q;
   logic                            lsb_done_q;
   logic [8*ICACHE_BLOCK_BYTES-1:0] ic_block_q;
   logic [31:0]                     lsb_rdata_q;
   logic                            io_stall;

`ifdef MEM_CTRL_IO_FULL_STALL_EN
   assign io_stall = io_buffer_full && (state_q == LSB_WRITE) &&
                     (mem_a_q[17:16] == IO_ADDR_SEL);
`else
   logic unused_io_full;
   assign unused_io_full = io_buffer_full;
   assign io_stall       = 1'b0;
`endif

   assign mem_a     = mem_a_q;
   assign mem_dout  = mem_dout_q;
   assign mem_wr    = mem_wr_q & rdy_in & ~io_stall;
   assign ic_done   = ic_done_q;
   assign ic_block  = ic_block_q;
   assign lsb_done  = lsb_done_q;
   assign lsb_rdata = lsb_rdata_q;

   // Merge the byte returned for the previous address into the assembly register.
   always_comb begin
      asm_d = shreg_q;
      for (int unsigned b = 0; b < BUF_BYTES; b++) begin
         if (cnt_q == CW'(b + 1)) asm_d[8*b +: 8] = mem_din;
      end
   end

   // Transaction FSM: arbitration, byte sequencing and registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         shreg_q     <= '0;
         mem_a_q     <= '0;
         mem_dout_q  <= '0;
         mem_wr_q    <= 1'b0;
         ic_done_q   <= 1'b0;
         lsb_done_q  <= 1'b0;
         ic_block_q  <= '0;
         lsb_rdata_q <= '0;
      end else if (rdy_in) begin
         case (state_q)
            IDLE: begin
               if (!clear_in) begin
                  if (lsb_req) begin
                     mem_a_q <= lsb_addr;
                     cnt_q   <= '0;
                     len_q   <= CW'(lsb_bytes(lsb_width));
                     if (lsb_wr) begin
                        // Store data is shifted out of the assembly register a byte at a time.
                        shreg_q    <= BUF_W'(lsb_wdata);
                        mem_dout_q <= lsb_wdata[7:0];
                        mem_wr_q   <= 1'b1;
                        state_q    <= LSB_WRITE;
                     end else begin
                        shreg_q <= '0;
                        state_q <= LSB_READ;
                     end
                  end else if (ic_req) begin
                     mem_a_q <= 32'(ic_addr);
                     cnt_q   <= '0;
                     len_q   <= CW'(ICACHE_BLOCK_BYTES);
                     shreg_q <= '0;
                     state_q <= IC_READ;
                  end
               end
            end
            IC_READ, LSB_READ: begin
               if (clear_in) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  mem_a_q <= '0;
               end else begin
                  shreg_q <= asm_d;
                  cnt_q   <= cnt_q + 1'b1;
                  if (cnt_q == len_q) begin
                     state_q <= DONE;
                     mem_a_q <= '0;
                     if (state_q == IC_READ) begin
                        ic_block_q <= asm_d[8*ICACHE_BLOCK_BYTES-1:0];
                        ic_done_q  <= 1'b1;
                     end else begin
                        lsb_rdata_q <= asm_d[31:0];
                        lsb_done_q  <= 1'b1;
                     end
                  end else if (cnt_q == len_q - 1'b1) begin
                     // Last address issued; this cycle only collects the final byte.
                     mem_a_q <= '0;
                  end else begin
                     mem_a_q <= mem_a_q + 32'd1;
                  end
               end
            end
            LSB_WRITE: begin
               if (!io_stall) begin
                  if (cnt_q == len_q - 1'b1) begin
                     state_q    <= DONE;
                     cnt_q      <= '0;
                     mem_wr_q   <= 1'b0;
                     mem_a_q    <= '0;
                     mem_dout_q <= '0;
                     lsb_done_q <= 1'b1;
                  end else begin
                     cnt_q      <= cnt_q + 1'b1;
                     mem_a_q    <= mem_a_q + 32'd1;
                     shreg_q    <= shreg_q >> 8;
                     mem_dout_q <= shreg_q[15:8];
                  end
               end
            end
            DONE: begin
               state_q    <= IDLE;
               cnt_q      <= '0;
               ic_done_q  <= 1'b0;
               lsb_done_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a transaction-level reference model.
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_in, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        ic_req, ic_done;
   logic [31:0] ic_addr;
   logic [63:0] ic_block;
   logic        lsb_req, lsb_wr, lsb_done;
   logic [1:0]  lsb_width;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

   mem_ctrl #(.ICACHE_BLOCK_BYTES(8), .ADDR_WIDTH(32)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_block(ic_block),
      .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_width(lsb_width), .lsb_addr(lsb_addr),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
   wr_t         wq[$];
   logic [7:0]  ram [logic [31:0]];
   logic [63:0] exp_ic = '0, pend_ic = '0;
   logic [31:0] exp_rd = '0, pend_rd = '0;
   bit          pend_ic_v = 0, pend_rd_v = 0, busy = 0;
   logic [31:0] tr_a [0:127];
   logic        tr_w [0:127];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   // RAM contents: explicit entries, otherwise a fixed address pattern.
   function automatic logic [7:0] ram_at(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return a[7:0] ^ 8'h5A;
   endfunction

   function automatic logic [63:0] model_read(input logic [31:0] a, input int unsigned n);
      logic [63:0] v = '0;
      for (int unsigned k = 0; k < n; k++) v[8*k +: 8] = ram_at(a + k);
      return v;
   endfunction

   // RAM shares the global enable: its read register only advances while rdy_in is high.
   always @(posedge clk_in) if (rdy_in) mem_din <= ram_at(mem_a);

   // Per-cycle comparison against the model.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (!rdy_in) chk("wr_gated_by_rdy", mem_wr, 0);
         if (mem_wr) begin
            if (wq.size() == 0) chk("unexpected_write", mem_wr, 0);
            else begin
               chk("wr_addr", mem_a, wq[0].a);
               chk("wr_data", mem_dout, wq[0].d);
               void'(wq.pop_front());
            end
         end else if (!busy) begin
            chk("idle_mem_a", mem_a, 0);
            chk("idle_mem_dout", mem_dout, 0);
         end
         chk("single_done", ic_done & lsb_done, 0);
         if (ic_done) begin
            chk("ic_done_expected", pend_ic_v, 1);
            exp_ic    = pend_ic;
            pend_ic_v = 0;
         end
         if (lsb_done) begin
            chk("lsb_done_expected", pend_rd_v, 1);
            exp_rd    = pend_rd;
            pend_rd_v = 0;
         end
         chk("ic_block_held", ic_block, exp_ic);
         chk("lsb_rdata_held", lsb_rdata, exp_rd);
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Advance until the selected done pulse; optional rdy_in drop and io_buffer_full release.
   task automatic run(input bit is_ic, input int maxc, input int rdy_off_at,
                      input int rdy_off_len, input int full_off_at, output int n);
      bit seen = 0;
      n = 0;
      while (!seen && n < maxc) begin
         tick();
         n++;
         tr_a[n] = mem_a;
         tr_w[n] = mem_wr;
         seen = is_ic ? ic_done : lsb_done;
         if (n == rdy_off_at) rdy_in = 1'b0;
         if (n == rdy_off_at + rdy_off_len) rdy_in = 1'b1;
         if (n == full_off_at) io_buffer_full = 1'b0;
      end
      chk("done_within_budget", seen, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, wc;
      logic [63:0] v;
      ram[32'h100] = 8'h11; ram[32'h101] = 8'h22;
      ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
      rst_in = 1; rdy_in = 1; clear_in = 0; io_buffer_full = 0;
      ic_req = 0; ic_addr = '0; lsb_req = 0; lsb_wr = 0; lsb_width = '0;
      lsb_addr = '0; lsb_wdata = '0;
      tick(); tick();
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_dout", mem_dout, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_ic_done", ic_done, 0);
      chk("rst_lsb_done", lsb_done, 0);
      chk("rst_ic_block", ic_block, 0);
      chk("rst_lsb_rdata", lsb_rdata, 0);
      rst_in = 0;
      tick();

      // Word read at 0x100.
      v = model_read(32'h100, 4);
      chk("model_word_literal", v, 64'h44332211);
      pend_rd = 32'(v); pend_rd_v = 1; busy = 1;
      lsb_req = 1; lsb_wr = 0; lsb_width = 2'd2; lsb_addr = 32'h100;
      run(0, 40, -1, 0, -1, n);
      lsb_req = 0; busy = 0;
      chk("word_read_cycles", n, 6);
      for (int k = 0; k < 4; k++) chk("word_read_addr", tr_a[k+1], 32'h100 + k);
      chk("word_read_data", lsb_rdata, 32'h44332211);
      tick();

      // Simultaneous requests: store wins, then the fill.
      v = model_read(32'h40, 8);
      chk("model_block_literal", v, 64'h1D1C1F1E19181B1A);
      pend_ic = v; pend_ic_v = 1;
      pend_rd = exp_rd; pend_rd_v = 1;
      wq.push_back('{a: 32'h200, d: 8'hA5});
      busy = 1;
      ic_req = 1; ic_addr = 32'h40;
      lsb_req = 1; lsb_wr = 1; lsb_width = 2'd0; lsb_addr = 32'h200; lsb_wdata = 32'h123456A5;
      run(0, 20, -1, 0, -1, n);
      lsb_req = 0;
      chk("store_first_cycles", n, 2);
      chk("store_write_cycle", tr_w[1], 1);
      run(1, 40, -1, 0, -1, n);
      ic_req = 0; busy = 0;
      chk("fill_after_store_cycles", n, 11);
      chk("fill_block", ic_block, 64'h1D1C1F1E19181B1A);
      chk("store_writes_consumed", wq.size(), 0);
      tick();

      // Fill aborted by clear on its third cycle, then a half read.
      busy = 1;
      ic_req = 1; ic_addr = 32'h80;
      tick(); tick(); tick();
      clear_in = 1; ic_req = 0;
      tick();
      clear_in = 0;
      chk("abort_mem_a", mem_a, 0);
      v = model_read(32'h300, 2);
      chk("model_half_literal", v, 64'h5B5A);
      pend_rd = 32'(v); pend_rd_v = 1;
      lsb_req = 1; lsb_wr = 0; lsb_width = 2'd1; lsb_addr = 32'h300;
      run(0, 40, -1, 0, -1, n);
      lsb_req = 0; busy = 0;
      chk("read_after_abort_cycles", n, 4);
      chk("half_read_data", lsb_rdata, 32'h00005B5A);
      tick();

      // Half store into the IO region with the transmit buffer full for 3 cycles.
      pend_rd = exp_rd; pend_rd_v = 1;
      wq.push_back('{a: 32'h30000, d: 8'hEF});
      wq.push_back('{a: 32'h30001, d: 8'hBE});
      busy = 1; io_buffer_full = 1;
      lsb_req = 1; lsb_wr = 1; lsb_width = 2'd1; lsb_addr = 32'h30000; lsb_wdata = 32'h0000BEEF;
      run(0, 40, -1, 0, 4, n);
      lsb_req = 0; busy = 0; io_buffer_full = 0;
`ifdef MEM_CTRL_IO_FULL_STALL_EN
      chk("io_store_cycles", n, 6);
      wc = 0;
      for (int k = 1; k <= 4; k++) wc += int'(tr_w[k]);
      chk("io_store_stalled_writes", wc, 0);
`else
      chk("io_store_cycles", n, 3);
      chk("io_store_first_write", tr_w[1], 1);
      chk("io_store_first_addr", tr_a[1], 32'h30000);
`endif
      chk("io_store_writes_consumed", wq.size(), 0);
      tick();

      // Word read with rdy_in low for two cycles.
      v = model_read(32'h100, 4);
      pend_rd = 32'(v); pend_rd_v = 1; busy = 1;
      lsb_req = 1; lsb_wr = 0; lsb_width = 2'd2; lsb_addr = 32'h100;
      run(0, 40, 2, 2, -1, n);
      lsb_req = 0; busy = 0;
      chk("frozen_read_cycles", n, 8);
      for (int k = 2; k <= 4; k++) chk("frozen_mem_a", tr_a[k], 32'h101);
      chk("frozen_wr_a", tr_w[3], 0);
      chk("frozen_wr_b", tr_w[4], 0);
      chk("frozen_read_data", lsb_rdata, 32'h44332211);
      tick();

      // Reset in the middle of a word store.
      pend_rd_v = 1; busy = 1;
      wq.push_back('{a: 32'h400, d: 8'hEF});
      wq.push_back('{a: 32'h401, d: 8'hBE});
      wq.push_back('{a: 32'h402, d: 8'hAD});
      wq.push_back('{a: 32'h403, d: 8'hDE});
      lsb_req = 1; lsb_wr = 1; lsb_width = 2'd2; lsb_addr = 32'h400; lsb_wdata = 32'hDEADBEEF;
      tick(); tick();
      chk("store_in_progress", mem_wr, 1);
      #2 rst_in = 1;
      #1;
      chk("async_rst_mem_wr", mem_wr, 0);
      chk("async_rst_mem_a", mem_a, 0);
      chk("async_rst_mem_dout", mem_dout, 0);
      chk("async_rst_ic_block", ic_block, 0);
      chk("async_rst_lsb_rdata", lsb_rdata, 0);
      chk("async_rst_dones", {ic_done, lsb_done}, 0);
      lsb_req = 0; wq.delete();
      pend_rd_v = 0; pend_ic_v = 0; exp_ic = '0; exp_rd = '0; busy = 0;
      tick(); tick();
      rst_in = 0;
      wc = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         wc += int'(mem_wr);
      end
      chk("no_write_after_reset", wc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ICACHE_BLOCK_BYTES, default 8, bytes per instruction-cache block fill.
REQ-002 Parameter ADDR_WIDTH, default 32, request address width.
REQ-003 clk_in  input  1  single system clock.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 rdy_in  input  1  global enable; low freezes the block.
REQ-006 clear_in  input  1  misprediction flush.
REQ-007 mem_din  input  8  RAM read byte, valid the cycle after the address is issued.
REQ-008 mem_dout  output  8  RAM write byte.
REQ-009 mem_a  output  32  RAM byte address.
REQ-010 mem_wr  output  1  1 = write, 0 = read.
REQ-011 io_buffer_full  input  1  UART transmit buffer full.
REQ-012 ic_req, ic_addr  input  1 / ADDR_WIDTH  I-cache block-fill request and block-aligned address.
REQ-013 ic_done, ic_block  output  1 / 8*ICACHE_BLOCK_BYTES  one-cycle fill-complete pulse and the filled block.
REQ-014 lsb_req, lsb_wr, lsb_width, lsb_addr, lsb_wdata  input  1/1/2/32/32  load/store request; width 0 = byte, 1 = half, 2 = word.
REQ-015 lsb_done, lsb_rdata  output  1 / 32  one-cycle completion pulse and zero-extended load data.

Function
REQ-016 FSM states: IDLE, IC_READ, LSB_READ, LSB_WRITE, DONE.
REQ-017 Requests are sampled only in IDLE; lsb_req has priority over ic_req when both are high in the same cycle.
REQ-018 An accepted transaction is never preempted.
REQ-019 Read of N bytes: address addr+k is driven on cycle k (k = 0..N-1) with mem_wr = 0; mem_din captured on cycle k+1 goes into bits [8k+7:8k] (little-endian); total N+1 cycles in the read state.
REQ-020 Write of N bytes: addr+k and lsb_wdata[8k+7:8k] are driven with mem_wr = 1 on cycle k; total N cycles in the write state.
REQ-021 N = 1/2/4 for lsb_width 0/1/2; N = ICACHE_BLOCK_BYTES for an IC fill.
REQ-022 DONE lasts one cycle and raises exactly one of ic_done or lsb_done; the next state is IDLE.
REQ-023 Data outputs hold their value until the next completion.
REQ-024 mem_wr is 0 in every cycle other than a write-byte cycle.
REQ-025 When no write is in progress, mem_a = 0 and mem_dout = 0.
REQ-026 rdy_in low: no state, counter or output-register change; mem_wr is forced to 0.
REQ-027 clear_in during IC_READ or LSB_READ: the transaction is aborted, FSM goes to IDLE next cycle, and no done pulse is raised.
REQ-028 clear_in during LSB_WRITE has no effect; the store completes.
REQ-029 clear_in in IDLE blocks acceptance in that cycle.
REQ-030 A requester deasserts req in the cycle it observes done; a req still high in IDLE is treated as a new request.

Reset
REQ-031 On rst_in: state = IDLE, byte counter = 0, mem_a = 0, mem_dout = 0, mem_wr = 0, ic_done = 0, lsb_done = 0, ic_block = 0, lsb_rdata = 0; effective immediately, including mid-transaction.

Configuration
REQ-032 With MEM_CTRL_IO_FULL_STALL_EN defined: a write byte whose address has [17:16] == 2'b11 is not issued while io_buffer_full = 1; mem_wr stays 0, the counter holds, and the byte is issued in the first cycle io_buffer_full = 0.
REQ-033 Without MEM_CTRL_IO_FULL_STALL_EN: io_buffer_full is ignored.

Structure
REQ-034 The FSM state enum, the lsb_width encodings and the IO address-match constant (2'b11 at [17:16]) belong in the shared package cpu_pkg.
REQ-035 No sub-module; a single FSM with one byte counter and one shift/assembly register.

Verification
REQ-036 LSB word read at 0x100, RAM bytes 11,22,33,44 -> addresses 0x100..0x103 on 4 consecutive cycles, lsb_done after 5 cycles, lsb_rdata = 0x44332211.
REQ-037 ic_req and lsb_req (byte store 0xA5 to 0x200) asserted in the same cycle -> a single mem_wr pulse with mem_a = 0x200 and mem_dout = 0xA5; lsb_done; then an 8-byte fill from ic_addr; ic_done after 9 cycles.
REQ-038 clear_in on the 3rd cycle of an IC fill -> no ic_done; IDLE next cycle; a following lsb_req is accepted.
REQ-039 Half store 0xBEEF to 0x30000 with io_buffer_full high for 3 cycles (macro on) -> no write for 3 cycles, then 0xEF at 0x30000 and 0xBE at 0x30001; macro off -> no stall.
REQ-040 rdy_in low for 2 cycles mid word-read -> mem_a frozen and mem_wr = 0; the result is identical to REQ-036, only 2 cycles later.
REQ-041 rst_in asserted mid-store -> all outputs 0 without waiting for a clock edge; no further mem_wr.
